// File: rtl/boxcar_pkg.sv
// Shared constants for the boxcar averager: sample and window sizing, register map, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package boxcar_pkg;

  localparam int DW       = 14;             // signed sample width
  localparam int LOG2_MAX = 7;              // largest log2 window
  localparam int DEPTH    = 1 << LOG2_MAX;  // circular buffer depth (128)
  localparam int SW       = DW + LOG2_MAX;  // running-sum width, exact for DEPTH samples

  // PS register map (byte addresses)
  localparam logic [15:0] REG_WIN   = 16'h0000;
  localparam logic [15:0] REG_CTRL  = 16'h0004;
  localparam logic [15:0] REG_COUNT = 16'h0008;
  localparam logic [15:0] REG_OUT   = 16'h000C;

  // REG_CTRL bit positions
  localparam int HOLD_BIT  = 0;
  localparam int CLEAR_BIT = 1;

  typedef enum logic {
    FILL = 1'b0,  // fewer than W samples since the last flush
    RUN  = 1'b1   // window full, oldest sample is retired every clock
  } state_t;

endpackage

// File: rtl/boxcar_averager_if.sv
// PS register-bus bundle for the boxcar averager.
// Latency: ack/rdata return one clock after a wen/ren strobe.
// Backpressure: none, every strobe is accepted and acknowledged.
// Signals: addr (byte address), wen/ren (strobes), wdata (write data),
//          ack (one-cycle acknowledge), rdata (read data, valid with ack).
interface boxcar_averager_if;
  logic [15:0] addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output addr, output wen, output ren, output wdata,
                  input  ack,  input  rdata);
  modport slave  (input  addr, input  wen, input  ren, input  wdata,
                  output ack,  output rdata);
endinterface

// File: rtl/boxcar_ram.sv
// Circular sample buffer: one synchronous write port, one asynchronous read port.
// Latency: read is combinational and returns the contents from before the current edge's write.
// Backpressure: none, one write per clock when i_we is high.
// Ports: clk_i, i_we/i_waddr/i_wdat (write), i_raddr/o_rdat (read).
module boxcar_ram #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 7
) (
  input  logic                     clk_i,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic signed [DATA_W-1:0] i_wdat,
  input  logic [ADDR_W-1:0]        i_raddr,
  output logic signed [DATA_W-1:0] o_rdat
);

  // Contents are deliberately not reset: the averager gates stale data
  // with its fill count, so old samples are never summed.
  logic signed [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  // Read-before-write: when i_raddr == i_waddr the old sample is returned.
  assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/boxcar_averager.sv
// Moving-average filter over the last 2^log2_win samples, one sample per clock.
// Latency: dat_i sampled at edge k appears in dat_o after edge k+2.
// Backpressure: none, dat_i is consumed every clock; PS bus strobes are acked the next clock.
// Ports: clk_i, rst_i (sync, active-high), dat_i/dat_o (signed samples), bus (PS register slave).
module boxcar_averager
  import boxcar_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic signed [DW-1:0] dat_i,
  output logic signed [DW-1:0] dat_o,
  boxcar_averager_if.slave     bus
);

  logic [2:0]            r_log2_win;
  logic                  r_hold;
  logic [LOG2_MAX:0]     r_count;
  logic [LOG2_MAX-1:0]   r_wp;
  logic signed [DW-1:0]  r_x;
  logic signed [DW-1:0]  r_old;
  logic signed [SW-1:0]  r_sum;
  logic signed [DW-1:0]  r_dat_o;
  logic                  r_ack;
  logic [31:0]           r_rdata;
  state_t                r_state;
  state_t                w_state_nxt;

  logic [LOG2_MAX:0]     w_win;
  logic [LOG2_MAX-1:0]   w_raddr;
  logic signed [DW-1:0]  w_rdat;
  logic                  w_flush;
  logic [LOG2_MAX:0]     w_count_nxt;
  logic signed [SW-1:0]  w_x_ext;
  logic signed [SW-1:0]  w_old_ext;
  logic signed [SW-1:0]  w_sum_nxt;
  logic signed [SW-1:0]  w_avg;
  logic [31:0]           w_rd_mux;

  assign w_win = {{LOG2_MAX{1'b0}}, 1'b1} << r_log2_win;
  // Oldest sample in the window; at W=128 this is the slot about to be overwritten.
  assign w_raddr = r_wp - w_win[LOG2_MAX-1:0];

  boxcar_ram #(.DATA_W(DW), .ADDR_W(LOG2_MAX)) u_ram (
    .clk_i   (clk_i),
    .i_we    (!rst_i),
    .i_waddr (r_wp),
    .i_wdat  (dat_i),
    .i_raddr (w_raddr),
    .o_rdat  (w_rdat)
  );

  // Any write to the window register, or a CTRL write with clear set, restarts the average.
  assign w_flush = bus.wen && ((bus.addr == REG_WIN) ||
                               ((bus.addr == REG_CTRL) && bus.wdata[CLEAR_BIT]));

  assign w_count_nxt = (r_count == w_win) ? r_count : r_count + {{LOG2_MAX{1'b0}}, 1'b1};
  assign w_x_ext     = {{LOG2_MAX{r_x[DW-1]}}, r_x};
  assign w_old_ext   = {{LOG2_MAX{r_old[DW-1]}}, r_old};
  assign w_sum_nxt   = r_sum + w_x_ext - w_old_ext;
  assign w_avg       = r_sum >>> r_log2_win;  // floor average

  always_comb begin
    w_state_nxt = r_state;
    if (w_flush) begin
      w_state_nxt = FILL;
    end else if (w_count_nxt == w_win) begin
      w_state_nxt = RUN;
    end else begin
      w_state_nxt = FILL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sample pipeline and running sum. The buffer write pointer keeps advancing through a
  // flush; the zeroed count keeps those slots out of the sum until they are refilled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp    <= '0;
      r_count <= '0;
      r_x     <= '0;
      r_old   <= '0;
      r_sum   <= '0;
    end else begin
      r_wp <= r_wp + {{(LOG2_MAX-1){1'b0}}, 1'b1};
      if (w_flush) begin
        r_count <= '0;
        r_x     <= '0;
        r_old   <= '0;
        r_sum   <= '0;
      end else begin
        r_count <= w_count_nxt;
        r_x     <= dat_i;
        r_old   <= (r_state == RUN) ? w_rdat : '0;
        r_sum   <= w_sum_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dat_o <= '0;
    end else if (!r_hold) begin
      r_dat_o <= w_avg[DW-1:0];
    end
  end

  assign dat_o = r_dat_o;

  always_comb begin
    w_rd_mux = '0;
    case (bus.addr)
      REG_WIN:   w_rd_mux = {29'b0, r_log2_win};
      REG_CTRL:  w_rd_mux = {31'b0, r_hold};
      REG_COUNT: w_rd_mux = {{(31-LOG2_MAX){1'b0}}, r_count};
      REG_OUT:   w_rd_mux = {{(32-DW){r_dat_o[DW-1]}}, r_dat_o};
      default:   w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_log2_win <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_ack   <= bus.wen | bus.ren;
      r_rdata <= bus.ren ? w_rd_mux : '0;
      if (bus.wen) begin
        case (bus.addr)
          REG_WIN:  r_log2_win <= bus.wdata[2:0];
          REG_CTRL: r_hold     <= bus.wdata[HOLD_BIT];
          default:  ;
        endcase
      end
    end
  end

  assign bus.ack   = r_ack;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_boxcar_averager.sv
module tb_boxcar_averager;
  import boxcar_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] dout;

  boxcar_averager_if bus_if();

  boxcar_averager dut (
    .clk_i (clk),
    .rst_i (rst),
    .dat_i (din),
    .dat_o (dout),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural reference: history of accepted samples since the last flush/reset,
  // window averages computed directly from that history.
  int          hist[$];
  int          m_log2  = 0;
  int          m_hold  = 0;
  int          m_sum   = 0;   // window total visible to the output stage
  int          m_total = 0;   // window total including the sample just accepted
  int          m_dout  = 0;
  int          m_ack   = 0;
  logic [31:0] m_rdata = '0;

  function automatic int fdiv(int s, int w);
    int q;
    q = s / w;
    if ((s % w != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int mwin();
    return 1 << m_log2;
  endfunction

  function automatic int mcount();
    return (hist.size() < mwin()) ? hist.size() : mwin();
  endfunction

  function automatic int wtotal();
    int s;
    int n;
    s = 0;
    n = mcount();
    for (int i = hist.size() - n; i < hist.size(); i++) s += hist[i];
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model with the currently driven inputs, clock once, compare.
  task automatic cycle();
    int          flush;
    int          ndo;
    logic [31:0] rd;
    if (rst) begin
      hist.delete();
      m_log2 = 0; m_hold = 0; m_sum = 0; m_total = 0;
      m_dout = 0; m_ack = 0; m_rdata = '0;
    end else begin
      flush = bus_if.wen && ((bus_if.addr == 16'h0) ||
                             ((bus_if.addr == 16'h4) && bus_if.wdata[1]));
      ndo = (m_hold != 0) ? m_dout : fdiv(m_sum, mwin());
      rd = '0;
      if (bus_if.ren) begin
        case (bus_if.addr)
          16'h0000: rd = m_log2;
          16'h0004: rd = m_hold;
          16'h0008: rd = mcount();
          16'h000C: rd = m_dout;
          default:  rd = '0;
        endcase
      end
      m_sum = flush ? 0 : m_total;
      if (flush) begin
        hist.delete();
      end else begin
        hist.push_back(int'(din));
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      m_total = wtotal();
      if (bus_if.wen) begin
        if (bus_if.addr == 16'h0) m_log2 = int'(bus_if.wdata[2:0]);
        if (bus_if.addr == 16'h4) m_hold = int'(bus_if.wdata[0]);
      end
      m_dout  = ndo;
      m_ack   = (bus_if.wen || bus_if.ren) ? 1 : 0;
      m_rdata = rd;
    end
    @(posedge clk);
    #1;
    check("dat_o", int'(dout), m_dout);
    check("ack", int'(bus_if.ack), m_ack);
    if (m_ack != 0) check("rdata", int'(bus_if.rdata), int'(m_rdata));
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    bus_if.wen = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    cycle();
    bus_if.wen = 1'b0; bus_if.wdata = '0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] r);
    bus_if.ren = 1'b1; bus_if.addr = a;
    cycle();
    r = bus_if.rdata;
    bus_if.ren = 1'b0;
  endtask

  typedef struct {
    int log2;
    int d0;
    int d1;
    int ncyc;
    int exp_dout;
    int exp_cnt;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[7];
    logic [31:0] r;
    int          v[0:140];
    int          exp_step[7];
    int          nonmono;
    int          frozen;
    int          sel;
    logic [15:0] raddrs[6];

    vt[0] = '{0,   100,   100,  10,   100,   1};
    vt[1] = '{2,  1000,  1000,  12,  1000,   4};
    vt[2] = '{1,     1,     0,  20,     0,   2};
    vt[3] = '{1,    -1,     0,  20,    -1,   2};
    vt[4] = '{3,    -5,    -5,  20,    -5,   8};
    vt[5] = '{7,  8191,  8191, 200,  8191, 128};
    vt[6] = '{7, -8192, -8192, 200, -8192, 128};
    exp_step = '{0, 0, 250, 500, 750, 1000, 1000};
    raddrs   = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10, 16'h2};

    rst = 1'b1; din = '0;
    bus_if.wen = 1'b0; bus_if.ren = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    cycle(); cycle();
    check("reset_dout", int'(dout), 0);
    check("reset_ack", int'(bus_if.ack), 0);

    // log2_win=0 straight out of reset: output follows input two clocks late.
    rst = 1'b0; din = 14'sd100;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      check("w1_latency", int'(dout), (i >= 3) ? 100 : 0);
    end
    bus_rd(16'h8, r);
    check("w1_count", int'(r), 1);

    // W=4 step response after flush.
    din = 14'sd1000;
    bus_wr(16'h0, 32'd2);
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("w4_step", int'(dout), exp_step[i]);
    end
    bus_rd(16'h8, r);
    check("w4_count", int'(r), 4);

    // Table-driven steady-state patterns.
    for (int t = 0; t < 7; t++) begin
      bus_wr(16'h0, 32'(vt[t].log2));
      for (int c = 0; c < vt[t].ncyc; c++) begin
        din = DW'((c % 2 == 0) ? vt[t].d0 : vt[t].d1);
        cycle();
      end
      check("tbl_dout", int'(dout), vt[t].exp_dout);
      bus_rd(16'h8, r);
      check("tbl_count", int'(r), vt[t].exp_cnt);
    end

    // W=128 full-scale ramp from -8192 to 8191.
    din = 14'sd8191;
    for (int i = 0; i <= 140; i++) begin
      cycle();
      v[i] = int'(dout);
    end
    nonmono = 0;
    for (int i = 1; i <= 140; i++) if (v[i] < v[i-1]) nonmono++;
    check("ramp_start", v[1], -8192);
    check("ramp_not_yet", (v[128] < 8191) ? 1 : 0, 1);
    check("ramp_reached", v[129], 8191);
    check("ramp_monotonic", nonmono, 0);

    // Bus behaviour.
    bus_wr(16'h0, 32'd3);
    check("wr_ack", int'(bus_if.ack), 1);
    bus_rd(16'h8, r);
    check("flush_count", int'(r), 0);
    cycle();
    check("ack_pulse", int'(bus_if.ack), 0);
    bus_rd(16'h0, r);
    check("rd_win", int'(r), 3);
    bus_rd(16'h10, r);
    check("rd_unmapped", int'(r), 0);

    // Hold freezes dat_o while the count keeps advancing.
    din = 14'sd200;
    bus_wr(16'h0, 32'd3);
    bus_wr(16'h4, 32'd1);
    frozen = int'(dout);
    for (int i = 0; i < 6; i++) begin
      din = DW'(300 + 10 * i);
      cycle();
      check("hold_frozen", int'(dout), frozen);
    end
    bus_rd(16'h8, r);
    check("hold_count", int'(r), 7);
    bus_wr(16'h4, 32'd0);

    // Clear bit flushes and reads back as 0.
    bus_wr(16'h4, 32'd2);
    bus_rd(16'h4, r);
    check("clear_reads0", int'(r), 0);

    // Reset in the middle of RUN with a read strobe pending.
    for (int i = 0; i < 20; i++) begin
      din = DW'(int'($urandom_range(0, 16383)) - 8192);
      cycle();
    end
    check("pre_reset_run", int'(dut.r_state), int'(RUN));
    rst = 1'b1; bus_if.ren = 1'b1; bus_if.addr = 16'h8;
    cycle();
    check("rst_dout", int'(dout), 0);
    check("rst_ack", int'(bus_if.ack), 0);
    check("rst_fsm", int'(dut.r_state), int'(FILL));
    rst = 1'b0; bus_if.ren = 1'b0;
    bus_rd(16'h0, r);
    check("rst_win", int'(r), 0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      din = DW'(int'($urandom_range(0, 16383)) - 8192);
      sel = int'($urandom_range(0, 99));
      if (sel < 2) begin
        bus_wr(16'h0, 32'($urandom_range(0, 7)));
      end else if (sel < 4) begin
        bus_wr(16'h4, 32'($urandom_range(0, 3)));
      end else if (sel < 14) begin
        bus_rd(raddrs[$urandom_range(0, 5)], r);
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/boxcar_averager.md
Name: boxcar_averager

Overview:
- Moving-average (boxcar) filter sitting directly downstream of the 14-bit signed adder stage.
- Averages the last 2^N samples, one new sample every clock, with N set from the PS register bus.
- Used to smooth summed signals before they reach the scope or DAC paths.
- Circular sample buffer plus running sum; no multipliers.

Parameters:
- DW, 14, sample width (signed).
- LOG2_MAX, 7, maximum log2 of the window; buffer depth is 2^LOG2_MAX = 128.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- dat_i  in  DW  signed input sample, consumed every clock.
- dat_o  out  DW  signed averaged output.
- addr  in  16  PS bus address.
- wen  in  1  PS write strobe.
- ren  in  1  PS read strobe.
- ack  out  1  PS acknowledge.
- rdata  out  32  PS read data.
- wdata  in  32  PS write data.

Interface decision: one clock (clk_i); reset rst_i is synchronous and active-high.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - Clear dat_o, ack, rdata, sum, pipeline registers, write pointer, count and log2_win.
  - FSM goes to FILL.
  - Buffer contents are not cleared.
- Window:
  - W = 2^log2_win, with log2_win in 0..7.
- Pipeline: three register stages.
  - Edge k:
    - x_r <= dat_i.
    - old_r <= (count==W) ? mem[wp-W mod 128] : 0.
    - mem[wp] <= dat_i.
    - wp <= wp+1 (wraps 127->0).
    - count <= min(count+1, W).
  - Edge k+1: sum <= sum + x_r - old_r.
  - Edge k+2: dat_o <= sum >>> log2_win, truncated to DW bits, unless hold=1.
- Latency: dat_i sampled at edge k is reflected in dat_o after edge k+2.
- Buffer read: read-before-write. At W=128, old_r gets the sample written 128 cycles earlier at the same address.
- Arithmetic:
  - sum is signed, DW+LOG2_MAX = 21 bits.
  - sum is the exact total of at most 128 samples and never overflows.
  - Output is the floor average via arithmetic shift; no saturation is needed.
- FSM states:
  - FILL: count<W, expired samples read as 0, so dat_o ramps up from a flush.
  - RUN: count==W.
  - FILL->RUN when count reaches W.
  - Any state -> FILL on flush.
- Flush, triggered by a write to log2_win or by a write with clear bit=1:
  - Next edge: count, sum, x_r and old_r go to 0; the current dat_i is not taken in.
  - dat_o follows the cleared sum per normal pipeline timing.
  - Flush while already in FILL is idempotent.
  - Writing the same log2_win value still flushes.
- Register map (byte addresses, addr[15:0]):
  - 0x00 RW: log2_win[2:0]; reset 0.
  - 0x04 RW: bit0 hold (freezes dat_o; internal pipeline keeps running). Write-only bit1 clear, self-clearing, reads 0.
  - 0x08 RO: {24'b0, count[7:0]}.
  - 0x0C RO: dat_o sign-extended to 32 bits.
  - Unmapped reads return 0; unmapped writes are ignored.
- Bus handshake:
  - ack is a one-cycle pulse on the edge after any cycle with wen|ren.
  - rdata is registered and valid while ack=1.
  - A write takes effect at the same edge that raises ack.
  - Back-to-back strobes each get their own ack.
- Reset mid-operation: overrides bus activity and flush; no ack is issued for a strobe in the reset cycle.

Decomposition:
- Shared package boxcar_pkg holds:
  - DW and LOG2_MAX.
  - Register address constants REG_WIN, REG_CTRL, REG_COUNT, REG_OUT.
  - Control bit indices HOLD_BIT and CLEAR_BIT.
  - FSM state enum {FILL, RUN}.
- One sub-module, boxcar_ram: 128 x DW circular buffer with one write port and one asynchronous read-before-write read port.
- FSM, sum, output stage and bus decode stay in the top module.

Test Plan:
- Reset, log2_win=0, dat_i=100 held -> dat_o=100 from the 3rd edge on; count reads 1.
- Write 0x00=2, then dat_i=1000 constant -> dat_o steps 250, 500, 750, 1000 on consecutive cycles, then stays at 1000; count reads 4.
- log2_win=7:
  - dat_i=-8192 for 200 cycles -> dat_o=-8192 with no overflow.
  - Then dat_i=8191 -> dat_o=8191 exactly 128 cycles later, monotonic in between.
- log2_win=1, dat_i alternating 1,0 -> dat_o=0. Alternating -1,0 -> dat_o=-1 (floor).
- Bus:
  - Write 0x00=3 -> ack one cycle later and a flush.
  - Read 0x00 -> rdata=3 with ack.
  - Read 0x10 -> rdata=0 with ack.
  - Write 0x04=1 -> dat_o frozen while count keeps advancing.
- Assert rst_i mid-RUN with ren high -> next edge: dat_o=0, ack=0, log2_win=0, FSM in FILL.
